// File: rtl/mcu_clksw_ctrl_if.sv
// Handshake bundle between the RCC register file and the system clock-switch sequencer.
interface mcu_clksw_ctrl_if;
   logic [1:0] sw_req;
   logic       pllon_req;
   logic       pll_lock;
   logic       stopreq;
   logic       err_clr;
   logic       pll_en;
   logic       clk_gate_en;
   logic [1:0] sws;
   logic       pll_rdy;
   logic       busy;
   logic       stopack;
   logic       timeout_err;

   modport master (
      output sw_req, pllon_req, pll_lock, stopreq, err_clr,
      input  pll_en, clk_gate_en, sws, pll_rdy, busy, stopack, timeout_err
   );

   modport slave (
      input  sw_req, pllon_req, pll_lock, stopreq, err_clr,
      output pll_en, clk_gate_en, sws, pll_rdy, busy, stopack, timeout_err
   );
endinterface

// File: rtl/mcu_clksw_ctrl.sv
// System clock source sequencer: PLL lock wait, gate-off/mux/gate-on switch, STOP arbitration.
// Define MCU_CLKSW_FAILSAFE_EN to fall back to HSI when PLL lock is lost while PLL is active.
module mcu_clksw_ctrl #(
   parameter int unsigned LOCK_TIMEOUT = 4095,
   parameter int unsigned GATE_CYCLES  = 4,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input logic             HCLK,
   input logic             PORESETn,
   mcu_clksw_ctrl_if.slave bus
);
   localparam int unsigned CntMax = (LOCK_TIMEOUT > GATE_CYCLES) ? LOCK_TIMEOUT : GATE_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] LockLast = CntW'(LOCK_TIMEOUT);
   localparam logic [CntW-1:0] GateLast = CntW'(GATE_CYCLES - 1);
   localparam logic [1:0] SrcHsi  = 2'b00;
   localparam logic [1:0] SrcPll  = 2'b10;
   localparam logic [1:0] SrcRsvd = 2'b11;

   typedef enum logic [2:0] {
      StIdle, StWaitLock, StGateOff, StSwitch, StGateOn, StStop
   } state_e;

   state_e                 state;
   logic [CntW-1:0]        cnt;
   logic [1:0]             target;
   logic [1:0]             sws;
   logic                   gate_en;
   logic                   busy;
   logic                   stopack;
   logic                   timeout_err;
   logic [SYNC_STAGES-1:0] sync;
   logic                   pll_rdy;
   logic                   in_gate_seq;

   always_ff @(posedge HCLK or negedge PORESETn) begin
      if (!PORESETn) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], bus.pll_lock};
      end
   end

   assign pll_rdy = sync[SYNC_STAGES-1];

   always_ff @(posedge HCLK or negedge PORESETn) begin
      if (!PORESETn) begin
         state       <= StIdle;
         cnt         <= '0;
         target      <= SrcHsi;
         sws         <= SrcHsi;
         gate_en     <= 1'b1;
         busy        <= 1'b0;
         stopack     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         // Any set of timeout_err below is a later assignment, so it beats a same-cycle clear.
         if (bus.err_clr) timeout_err <= 1'b0;
         unique case (state)
            StIdle: begin
`ifdef MCU_CLKSW_FAILSAFE_EN
               if (sws == SrcPll && !pll_rdy) begin
                  target      <= SrcHsi;
                  timeout_err <= 1'b1;
                  cnt         <= '0;
                  gate_en     <= 1'b0;
                  busy        <= 1'b1;
                  state       <= StGateOff;
               end else
`endif
               if (bus.stopreq) begin
                  stopack <= 1'b1;
                  state   <= StStop;
               end else if (bus.sw_req != sws && bus.sw_req != SrcRsvd && !timeout_err) begin
                  target <= bus.sw_req;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  if (bus.sw_req == SrcPll && !pll_rdy) begin
                     state <= StWaitLock;
                  end else begin
                     gate_en <= 1'b0;
                     state   <= StGateOff;
                  end
               end
            end
            StWaitLock: begin
               if (cnt == LockLast) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= StIdle;
               end else if (pll_rdy) begin
                  cnt     <= '0;
                  gate_en <= 1'b0;
                  state   <= StGateOff;
               end else begin
                  cnt <= cnt + CntW'(1);
               end
            end
            StGateOff: begin
               if (cnt == GateLast) begin
                  cnt   <= '0;
                  state <= StSwitch;
               end else begin
                  cnt <= cnt + CntW'(1);
               end
            end
            StSwitch: begin
               sws   <= target;
               state <= StGateOn;
            end
            StGateOn: begin
               if (cnt == GateLast) begin
                  cnt     <= '0;
                  gate_en <= 1'b1;
                  busy    <= 1'b0;
                  state   <= StIdle;
               end else begin
                  cnt <= cnt + CntW'(1);
               end
            end
            StStop: begin
               if (!bus.stopreq) begin
                  stopack <= 1'b0;
                  state   <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // The PLL must stay powered across the whole sequence that moves onto it.
   assign in_gate_seq = (state == StGateOff) || (state == StSwitch) || (state == StGateOn);

   assign bus.pll_en      = bus.pllon_req || (sws == SrcPll) || (state == StWaitLock) ||
                            (target == SrcPll && in_gate_seq);
   assign bus.clk_gate_en = gate_en;
   assign bus.sws         = sws;
   assign bus.pll_rdy     = pll_rdy;
   assign bus.busy        = busy;
   assign bus.stopack     = stopack;
   assign bus.timeout_err = timeout_err;
endmodule
